rob_commit_ctrl: RTL
====================

ROB_COMMIT_CTRL -- requirements
Module: rob_commit_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 15, number of in-flight entries (1..31); tags 1..DEPTH, tag 0 reserved for "no dependency".
REQ-002 SHALL have parameter TAG_W, default 5, tag width.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 rdy  in  1  global enable; when 0, all state and registered outputs are held.
REQ-006 alloc_req  in  1  dispatcher requests a tag.
REQ-007 alloc_dest  in  5  architectural destination register; 0 means no write.
REQ-008 alloc_grant  out  1  combinational; the request is accepted this cycle.
REQ-009 alloc_tag  out  TAG_W  combinational; the tag to use; valid while alloc_grant=1.
REQ-010 wb_valid  in  1  a result is broadcast.
REQ-011 wb_tag  in  TAG_W  producer tag.
REQ-012 wb_data  in  32  result value.
REQ-013 wb_mispredict  in  1  the producer is a mispredicted branch.
REQ-014 commit_valid  out  1  registered; drives RF rob_valid.
REQ-015 commit_dest  out  5  registered; drives RF dest.
REQ-016 commit_tag  out  TAG_W  registered; drives RF dest_depend.
REQ-017 commit_data  out  32  registered; drives RF rob_data.
REQ-018 flush  out  1  registered; drives RF wrong_commit.
REQ-019 full, empty  out  1 each  combinational occupancy status.

Function
REQ-020 Entries SHALL form a circular queue with head/tail pointers 0..DEPTH-1, wrapping DEPTH-1->0; the tag SHALL equal the slot index +1.
REQ-021 alloc_grant SHALL be alloc_req && !full && state==RUN; on grant, the tail entry gets valid=1, ready=0, dest=alloc_dest, and tail advances.
REQ-022 full SHALL use the pre-edge count (count==DEPTH); a same-cycle commit SHALL NOT free a slot for that cycle's allocation.
REQ-023 A wb_valid to a valid, not-ready entry SHALL set ready=1 and store data and the mispredict bit; a wb to an invalid or out-of-range tag (0 or >DEPTH) SHALL be ignored.
REQ-024 FSM states SHALL be RUN and FLUSH; reset enters RUN.
REQ-025 In RUN, when the head entry is valid and ready at an edge, that edge SHALL register commit_valid=1 with the head's dest, tag and data, invalidate the head and advance it (max 1 commit/cycle); otherwise commit_valid=0.
REQ-026 Latency: a wb at edge t SHALL commit at edge t+1 at the earliest, with no wb-to-commit bypass.
REQ-027 A committed head with mispredict=1 SHALL commit normally, and the FSM SHALL go to FLUSH.
REQ-028 In FLUSH (exactly one cycle): flush=1, commit_valid=0, alloc_grant=0, wb ignored; all entries invalidated, head=tail=0, count=0; return to RUN.
REQ-029 flush SHALL never be 1 in the same cycle as commit_valid.
REQ-030 Simultaneous alloc+commit SHALL leave count unchanged; simultaneous alloc+wb to the newly allocated tag SHALL be impossible (entry is not valid pre-edge) and SHALL be ignored.

Reset
REQ-031 On rst: all entries invalid, head=tail=count=0, state RUN, commit_valid=0, flush=0, commit_dest/tag/data=0; rst SHALL take priority over rdy.
REQ-032 After rst, outputs SHALL be empty=1, full=0.
REQ-033 rst during FLUSH SHALL abort it, with flush=0 next cycle.

Configuration
REQ-034 With ROB_COMMIT_CTRL_STATS_EN defined: outputs stat_commits[31:0] and stat_flushes[31:0] SHALL exist, reset to 0, and increment per commit and per FLUSH cycle (wrapping). Without it: no such ports or logic.

Structure
REQ-035 DEPTH default, TAG_W and the reserved tag-0 constant SHALL live in the shared const_def header.
REQ-036 The module SHALL be flat, with no sub-module; entry arrays and pointers are inline.

Verification
REQ-037 Reset, then alloc_dest=3 -> grant=1, tag=1; wb tag1 data=0x55 at edge t -> commit_valid=1, dest=3, tag=1, data=0x55 after edge t+1.
REQ-038 15 allocs with no wb -> full=1, 16th req grant=0; wb tag1 -> commit next cycle, and a same-cycle alloc is still refused.
REQ-039 Out-of-order wb tags 3,2,1 on consecutive cycles -> commits in tag order 1,2,3 on three consecutive cycles.
REQ-040 Tag 2 mispredicted -> tag 2 commits, next cycle flush=1 with no commit, then empty=1 and the next grant gives tag 1.
REQ-041 Wrap: allocate/commit 20 entries -> tags 1..15,1..5, with no loss.
REQ-042 rdy=0 for 3 cycles with a ready head -> outputs held and exactly one commit consumed.

Source files
------------

// File: rtl/rob_commit_ctrl_pkg.sv
// Shared constants and types for the reorder-buffer commit controller.
package rob_commit_ctrl_pkg;

  localparam int DEPTH_DEF = 15;
  localparam int TAG_W_DEF = 5;
  localparam int TAG_NONE  = 0;  // tag value meaning "no dependency"

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/rob_commit_ctrl.sv
// In-order commit controller: circular entry queue, out-of-order writeback, single-cycle flush.
// Optional commit/flush counters are built when ROB_COMMIT_CTRL_STATS_EN is defined.
//
// state | meaning
// RUN   | allocate, accept writebacks, commit the head when ready
// FLUSH | one cycle after a mispredicted commit; discard every entry
module rob_commit_ctrl
  import rob_commit_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             alloc_req,
  input  logic [4:0]       alloc_dest,
  output logic             alloc_grant,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic [31:0]      wb_data,
  input  logic             wb_mispredict,
  output logic             commit_valid,
  output logic [4:0]       commit_dest,
  output logic [TAG_W-1:0] commit_tag,
  output logic [31:0]      commit_data,
  output logic             flush,
  output logic             full,
  output logic             empty
`ifdef ROB_COMMIT_CTRL_STATS_EN
  ,
  output logic [31:0]      stat_commits,
  output logic [31:0]      stat_flushes
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  state_t           state, state_nxt;
  logic [DEPTH-1:0] ent_vld, ent_rdy, ent_mp;
  logic [4:0]       ent_dest [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [IDX_W-1:0] head, tail, wb_idx;
  logic [CNT_W-1:0] count;
  logic             in_run, do_commit, wb_hit;

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    return (p == LAST) ? '0 : p + IDX_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst)      state <= ST_RUN;
    else if (rdy) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RUN:   if (do_commit && ent_mp[head]) state_nxt = ST_FLUSH;
      ST_FLUSH: state_nxt = ST_RUN;
    endcase
  end

  // Full uses the pre-edge count, so a same-cycle commit never frees a slot for allocation.
  always_comb begin
    in_run      = (state == ST_RUN);
    full        = (count == CNT_W'(DEPTH));
    empty       = (count == '0);
    alloc_grant = alloc_req && !full && in_run;
    alloc_tag   = TAG_W'(tail) + TAG_W'(1);
    do_commit   = in_run && ent_vld[head] && ent_rdy[head];
    wb_idx      = IDX_W'(wb_tag - TAG_W'(1));
    wb_hit      = 1'b0;
    if (wb_valid && in_run && wb_tag != TAG_W'(TAG_NONE) && wb_tag <= TAG_W'(DEPTH))
      wb_hit = ent_vld[wb_idx] && !ent_rdy[wb_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_vld <= '0;
      ent_rdy <= '0;
      ent_mp  <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else if (rdy) begin
      if (!in_run) begin
        ent_vld <= '0;
        ent_rdy <= '0;
        ent_mp  <= '0;
        head    <= '0;
        tail    <= '0;
        count   <= '0;
      end else begin
        if (wb_hit) begin
          ent_rdy[wb_idx] <= 1'b1;
          ent_mp[wb_idx]  <= wb_mispredict;
        end
        if (do_commit) begin
          ent_vld[head] <= 1'b0;
          ent_rdy[head] <= 1'b0;
          head          <= ptr_inc(head);
        end
        if (alloc_grant) begin
          ent_vld[tail] <= 1'b1;
          ent_rdy[tail] <= 1'b0;
          ent_mp[tail]  <= 1'b0;
          tail          <= ptr_inc(tail);
        end
        case ({alloc_grant, do_commit})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Payload storage needs no reset; validity lives in ent_vld.
  always_ff @(posedge clk) begin
    if (!rst && rdy && in_run) begin
      if (wb_hit)      ent_data[wb_idx] <= wb_data;
      if (alloc_grant) ent_dest[tail]   <= alloc_dest;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      commit_valid <= 1'b0;
      commit_dest  <= '0;
      commit_tag   <= '0;
      commit_data  <= '0;
      flush        <= 1'b0;
    end else if (rdy) begin
      commit_valid <= do_commit;
      flush        <= !in_run;
      if (do_commit) begin
        commit_dest <= ent_dest[head];
        commit_tag  <= TAG_W'(head) + TAG_W'(1);
        commit_data <= ent_data[head];
      end
    end
  end

`ifdef ROB_COMMIT_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_commits <= '0;
      stat_flushes <= '0;
    end else if (rdy) begin
      if (do_commit) stat_commits <= stat_commits + 32'd1;
      if (!in_run)   stat_flushes <= stat_flushes + 32'd1;
    end
  end
`else
  // Counters compiled out.
`endif

endmodule
